// File: rtl/writeback_arbiter.sv
// Register-file write-back arbiter: the ALU result has priority, and long-latency results wait in a FIFO.
// It also keeps a 32-bit pending-destination scoreboard so decode can stall on registers still in flight.
module writeback_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [4:0]               lsu_rd,
  input  logic [31:0]              lsu_data,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  input  logic [4:0]               chk_rs1,
  input  logic [4:0]               chk_rs2,
  output logic                     busy_rs1,
  output logic                     busy_rs2,
  output logic                     RegWrite,
  output logic [4:0]               WriteReg,
  output logic [31:0]              WriteData,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pending_q, pending_d;
  logic          clr_valid_q, clr_valid_d;
  logic [4:0]    clr_rd_q, clr_rd_d;
  logic          reg_write_q, reg_write_d;
  logic [4:0]    write_reg_q, write_reg_d;
  logic [31:0]   write_data_q, write_data_d;

  logic [4:0]    fifo_rd_mem   [DEPTH];
  logic [31:0]   fifo_data_mem [DEPTH];

  logic          push;
  logic          pop;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  // Readiness and pop decisions look only at the registered count, so a full FIFO never accepts
  // a beat even in a cycle where it is also popping.
  assign lsu_ready = (count_q < CW'(DEPTH));
  assign push      = lsu_valid && lsu_ready;
  assign pop       = !alu_valid && (count_q != '0);
  assign head_rd   = fifo_rd_mem[rd_ptr_q];
  assign head_data = fifo_data_mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = 5'd0;
    write_data_d = 32'd0;
    if (alu_valid) begin
      reg_write_d  = (alu_rd != 5'd0);
      write_reg_d  = alu_rd;
      write_data_d = alu_data;
    end else if (pop) begin
      reg_write_d  = (head_rd != 5'd0);
      write_reg_d  = head_rd;
      write_data_d = head_data;
    end
  end

  // A popped destination is released one edge later, when the register file commits it.
  // A new issue to the same register at that edge keeps the bit set.
  always_comb begin
    pending_d   = pending_q;
    clr_valid_d = pop;
    clr_rd_d    = head_rd;
    if (clr_valid_q) pending_d[clr_rd_q] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) pending_d[issue_rd] = 1'b1;
  end

  assign busy_rs1 = (chk_rs1 != 5'd0) && pending_q[chk_rs1];
  assign busy_rs2 = (chk_rs2 != 5'd0) && pending_q[chk_rs2];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_mem[wr_ptr_q]   <= lsu_rd;
      fifo_data_mem[wr_ptr_q] <= lsu_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pending_q    <= '0;
      clr_valid_q  <= 1'b0;
      clr_rd_q     <= 5'd0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= 32'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pending_q    <= pending_d;
      clr_valid_q  <= clr_valid_d;
      clr_rd_q     <= clr_rd_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign RegWrite   = reg_write_q;
  assign WriteReg   = write_reg_q;
  assign WriteData  = write_data_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed-vector bench for writeback_arbiter: one table row per cycle, plus a hand-written
// sequence that asserts reset while the FIFO and scoreboard are occupied.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        busy_rs1;
  logic        busy_rs2;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .fifo_count(fifo_count)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic        erw;
    logic [4:0]  ewr;
    logic [31:0] ewd;
    logic        erdy;
    logic        eb1;
    logic        eb2;
    logic [2:0]  ecnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic av, logic [4:0] ard, logic [31:0] adata,
    logic lv, logic [4:0] lrd, logic [31:0] ldata,
    logic iv, logic [4:0] ird, logic [4:0] c1, logic [4:0] c2,
    logic erw, logic [4:0] ewr, logic [31:0] ewd,
    logic erdy, logic eb1, logic eb2, logic [2:0] ecnt);
    vec_t v;
    v.av = av;   v.ard = ard; v.adata = adata;
    v.lv = lv;   v.lrd = lrd; v.ldata = ldata;
    v.iv = iv;   v.ird = ird; v.c1 = c1; v.c2 = c2;
    v.erw = erw; v.ewr = ewr; v.ewd = ewd;
    v.erdy = erdy; v.eb1 = eb1; v.eb2 = eb2; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge and stay stable for the whole cycle.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    alu_valid   = v.av;  alu_rd   = v.ard;  alu_data = v.adata;
    lsu_valid   = v.lv;  lsu_rd   = v.lrd;  lsu_data = v.ldata;
    issue_valid = v.iv;  issue_rd = v.ird;
    chk_rs1     = v.c1;  chk_rs2  = v.c2;
  endtask

  task automatic driveIdle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
  endtask

  initial begin
    driveIdle();
    reset = 1'b1;
    #3;
    checkOutput("reset.RegWrite", {31'd0, RegWrite}, 32'd0);
    checkOutput("reset.WriteReg", {27'd0, WriteReg}, 32'd0);
    checkOutput("reset.WriteData", WriteData, 32'd0);
    checkOutput("reset.lsu_ready", {31'd0, lsu_ready}, 32'd1);
    checkOutput("reset.fifo_count", {29'd0, fifo_count}, 32'd0);
    checkOutput("reset.busy_rs1", {31'd0, busy_rs1}, 32'd0);
    #9 reset = 1'b0;

    //                 av ard  adata          lv lrd ldata          iv ird c1 c2  erw ewr ewd           rdy b1 b2 cnt
    vecs.push_back(mk(1, 5,  32'hDEADBEEF,  0, 0,  32'h0,        0, 0,  0, 0,  0, 0,  32'h0,        1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,        1, 7,  7, 0,  1, 5,  32'hDEADBEEF, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  7, 5,  0, 0,  32'h0,        1, 1, 0, 0));
    vecs.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  7, 5,  0, 0,  32'h0,        1, 1, 0, 0));
    vecs.push_back(mk(0, 0,  32'h0,         1, 7,  32'h12345678, 0, 0,  7, 5,  0, 0,  32'h0,        1, 1, 0, 0));
    vecs.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  7, 5,  0, 0,  32'h0,        1, 1, 0, 1));
    vecs.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  7, 5,  1, 7,  32'h12345678, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  7, 5,  0, 0,  32'h0,        1, 0, 0, 0));
    // ALU burst while the FIFO fills; the fifth beat is refused.
    vecs.push_back(mk(1, 10, 32'hA0,        1, 1,  32'h11,       0, 0,  0, 0,  0, 0,  32'h0,        1, 0, 0, 0));
    vecs.push_back(mk(1, 11, 32'hA1,        1, 2,  32'h22,       0, 0,  0, 0,  1, 10, 32'hA0,       1, 0, 0, 1));
    vecs.push_back(mk(1, 12, 32'hA2,        1, 3,  32'h33,       0, 0,  0, 0,  1, 11, 32'hA1,       1, 0, 0, 2));
    vecs.push_back(mk(1, 13, 32'hA3,        1, 4,  32'h44,       0, 0,  0, 0,  1, 12, 32'hA2,       1, 0, 0, 3));
    vecs.push_back(mk(1, 14, 32'hA4,        1, 9,  32'h99,       0, 0,  0, 0,  1, 13, 32'hA3,       0, 0, 0, 4));
    vecs.push_back(mk(1, 15, 32'hA5,        0, 0,  32'h0,        0, 0,  0, 0,  1, 14, 32'hA4,       0, 0, 0, 4));
    vecs.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  0, 0,  1, 15, 32'hA5,       0, 0, 0, 4));
    vecs.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  0, 0,  1, 1,  32'h11,       1, 0, 0, 3));
    vecs.push_back(mk(0, 0,  32'h0,         1, 20, 32'h200,      0, 0,  0, 0,  1, 2,  32'h22,       1, 0, 0, 2));
    vecs.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  0, 0,  1, 3,  32'h33,       1, 0, 0, 2));
    vecs.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  0, 0,  1, 4,  32'h44,       1, 0, 0, 1));
    // Destination 0 on both paths.
    vecs.push_back(mk(1, 0,  32'hFF,        1, 0,  32'hEE,       1, 0,  0, 0,  1, 20, 32'h200,      1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  0, 0,  0, 0,  32'h0,        1, 0, 0, 1));
    vecs.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  0, 0,  0, 0,  32'h0,        1, 0, 0, 0));
    // Fill to DEPTH, then offer a beat during a pop while full.
    vecs.push_back(mk(0, 0,  32'h0,         1, 21, 32'h21,       0, 0,  0, 0,  0, 0,  32'h0,        1, 0, 0, 0));
    vecs.push_back(mk(1, 16, 32'hB0,        1, 22, 32'h22,       0, 0,  0, 0,  0, 0,  32'h0,        1, 0, 0, 1));
    vecs.push_back(mk(1, 17, 32'hB1,        1, 23, 32'h23,       0, 0,  0, 0,  1, 16, 32'hB0,       1, 0, 0, 2));
    vecs.push_back(mk(1, 18, 32'hB2,        1, 24, 32'h24,       0, 0,  0, 0,  1, 17, 32'hB1,       1, 0, 0, 3));
    vecs.push_back(mk(0, 0,  32'h0,         1, 30, 32'h30,       0, 0,  0, 0,  1, 18, 32'hB2,       0, 0, 0, 4));
    vecs.push_back(mk(0, 0,  32'h0,         1, 30, 32'h30,       0, 0,  0, 0,  1, 21, 32'h21,       1, 0, 0, 3));
    vecs.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  0, 0,  1, 22, 32'h22,       1, 0, 0, 3));
    vecs.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  0, 0,  1, 23, 32'h23,       1, 0, 0, 2));
    vecs.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  0, 0,  1, 24, 32'h24,       1, 0, 0, 1));
    vecs.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  0, 0,  1, 30, 32'h30,       1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  0, 0,  0, 0,  32'h0,        1, 0, 0, 0));
    // Re-issue to r8 at the same edge its clear lands: the bit must stay set.
    vecs.push_back(mk(0, 0,  32'h0,         1, 8,  32'h88,       1, 8,  8, 0,  0, 0,  32'h0,        1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  8, 0,  0, 0,  32'h0,        1, 1, 0, 1));
    vecs.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,        1, 8,  8, 8,  1, 8,  32'h88,       1, 1, 1, 0));
    vecs.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  8, 8,  0, 0,  32'h0,        1, 1, 1, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #2;
      checkOutput($sformatf("v%0d.RegWrite", i), {31'd0, RegWrite}, {31'd0, vecs[i].erw});
      if (vecs[i].erw) begin
        checkOutput($sformatf("v%0d.WriteReg", i), {27'd0, WriteReg}, {27'd0, vecs[i].ewr});
        checkOutput($sformatf("v%0d.WriteData", i), WriteData, vecs[i].ewd);
      end
      checkOutput($sformatf("v%0d.lsu_ready", i), {31'd0, lsu_ready}, {31'd0, vecs[i].erdy});
      checkOutput($sformatf("v%0d.busy_rs1", i), {31'd0, busy_rs1}, {31'd0, vecs[i].eb1});
      checkOutput($sformatf("v%0d.busy_rs2", i), {31'd0, busy_rs2}, {31'd0, vecs[i].eb2});
      checkOutput($sformatf("v%0d.fifo_count", i), {29'd0, fifo_count}, {29'd0, vecs[i].ecnt});
    end

    // Reset with three queued beats and two pending destinations.
    @(posedge clk); #1;
    driveIdle();
    alu_valid = 1; alu_rd = 6; alu_data = 32'h6;
    lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h3;
    issue_valid = 1; issue_rd = 3;
    @(posedge clk); #1;
    lsu_rd = 4; lsu_data = 32'h4; issue_rd = 4;
    @(posedge clk); #1;
    lsu_rd = 5; lsu_data = 32'h5; issue_valid = 0;
    @(posedge clk); #1;
    lsu_valid = 0; chk_rs1 = 3; chk_rs2 = 4;
    #1;
    checkOutput("pre_reset.fifo_count", {29'd0, fifo_count}, 32'd3);
    checkOutput("pre_reset.busy_rs1", {31'd0, busy_rs1}, 32'd1);
    checkOutput("pre_reset.busy_rs2", {31'd0, busy_rs2}, 32'd1);
    checkOutput("pre_reset.RegWrite", {31'd0, RegWrite}, 32'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("mid_reset.fifo_count", {29'd0, fifo_count}, 32'd0);
    checkOutput("mid_reset.busy_rs1", {31'd0, busy_rs1}, 32'd0);
    checkOutput("mid_reset.busy_rs2", {31'd0, busy_rs2}, 32'd0);
    checkOutput("mid_reset.RegWrite", {31'd0, RegWrite}, 32'd0);
    checkOutput("mid_reset.lsu_ready", {31'd0, lsu_ready}, 32'd1);
    alu_valid = 0;
    @(posedge clk); #2 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #2;
      checkOutput($sformatf("post_reset%0d.RegWrite", k), {31'd0, RegWrite}, 32'd0);
      checkOutput($sformatf("post_reset%0d.fifo_count", k), {29'd0, fifo_count}, 32'd0);
      checkOutput($sformatf("post_reset%0d.busy_rs1", k), {31'd0, busy_rs1}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
